data_memory_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
- Requester 0 is the pipeline MEM stage; requester 1 is the debug/program-loader port.
- Sequences each access over a configurable memory latency and drives a stall to the pipeline while its access is pending.
- Sits between the MEM stage and the data memory instance.

---
 rtl/data_memory_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_arbiter
// Purpose  : Shares one single-port data memory between the pipeline MEM
//            stage (requester 0) and the debug/program-loader port
//            (requester 1). Each access takes MEM_LATENCY BUSY cycles plus a
//            DONE cycle; the pipeline is stalled while its access is pending.
// Ports    : clk, reset             - clock, asynchronous active-high reset
//            pipeReq/Write/Addr/Wdata, pipeDone, pipeStall - pipeline side
//            dbgReq/Write/Addr/Wdata,  dbgDone             - debug side
//            rdata                  - registered read data (valid with done)
//            memWrite/Addr/Wdata, memRdata - data memory side
// Options  : `define DATA_MEMORY_ARB_STARVE_GUARD_EN to force a debug grant
//            after STARVE_LIMIT consecutive pipeline grants while debug waits.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipeReq,
    input  logic                  pipeWrite,
    input  logic [ADDR_WIDTH-1:0] pipeAddr,
    input  logic [DATA_WIDTH-1:0] pipeWdata,
    output logic                  pipeDone,
    output logic                  pipeStall,
    input  logic                  dbgReq,
    input  logic                  dbgWrite,
    input  logic [ADDR_WIDTH-1:0] dbgAddr,
    input  logic [DATA_WIDTH-1:0] dbgWdata,
    output logic                  dbgDone,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter starts at MEM_LATENCY-1 so BUSY lasts exactly MEM_LATENCY cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                  state_q;
    logic                    owner_q;     // 0 = pipeline, 1 = debug
    logic                    write_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    pipeDone_q;
    logic                    dbgDone_q;
    logic                    memWrite_q;

    logic                    grantPipe;
    logic                    grantDbg;
    logic                    selWrite;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selWdata;

`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] waitCnt_q;
    logic [WAIT_W-1:0] waitCnt_d;
    logic              starved;

    assign starved = (waitCnt_q >= WAIT_W'(STARVE_LIMIT));

    // Counts pipeline wins while debug is waiting; never passes STARVE_LIMIT
    // because once it gets there the next arbitration goes to debug.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (!dbgReq || grantDbg) begin
            waitCnt_d = '0;
        end else if (grantPipe) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end
`else
    logic unused_starveLimit;
    assign unused_starveLimit = (STARVE_LIMIT != 0);
`endif

    // Grants only exist in IDLE, so everything downstream can use them as-is.
    always_comb begin
        grantPipe = 1'b0;
        grantDbg  = 1'b0;
        if (state_q == IDLE) begin
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
            grantDbg  = dbgReq & (~pipeReq | starved);
`else
            grantDbg  = dbgReq & ~pipeReq;
`endif
            grantPipe = pipeReq & ~grantDbg;
        end
    end

    assign selWrite = grantDbg ? dbgWrite  : pipeWrite;
    assign selAddr  = grantDbg ? dbgAddr   : pipeAddr;
    assign selWdata = grantDbg ? dbgWdata  : pipeWdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            write_q    <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            pipeDone_q <= 1'b0;
            dbgDone_q  <= 1'b0;
            memWrite_q <= 1'b0;
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
            waitCnt_q  <= '0;
`endif
        end else begin
            // Pulses default low; only the branches below raise them.
            pipeDone_q <= 1'b0;
            dbgDone_q  <= 1'b0;
            memWrite_q <= 1'b0;
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
            waitCnt_q  <= waitCnt_d;
`endif
            case (state_q)
                IDLE: begin
                    if (grantPipe || grantDbg) begin
                        owner_q    <= grantDbg;
                        write_q    <= selWrite;
                        addr_q     <= selAddr;
                        wdata_q    <= selWdata;
                        cnt_q      <= LAT_LOAD;
                        // With a one-cycle memory the first BUSY cycle is
                        // already the last one, so the strobe starts now.
                        memWrite_q <= selWrite && (LAT_LOAD == 4'd0);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        pipeDone_q <= ~owner_q;
                        dbgDone_q  <= owner_q;
                        if (!write_q) begin
                            rdata_q <= memRdata;
                        end
                        state_q    <= DONE;
                    end else begin
                        cnt_q      <= cnt_q - 4'd1;
                        // Strobe is registered, so it is raised one cycle
                        // ahead to land on the cycle where the count is 0.
                        memWrite_q <= write_q && (cnt_q == 4'd1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pipeDone  = pipeDone_q;
    assign dbgDone   = dbgDone_q;
    assign pipeStall = pipeReq & ~pipeDone_q;
    assign rdata     = rdata_q;
    assign memWrite  = memWrite_q;
    assign memAddr   = addr_q;
    assign memWdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_data_memory_arbiter
// Purpose  : Self-checking bench for data_memory_arbiter with a behavioural
//            data memory, a reference memory image and per-requester
//            scoreboards of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int L  = 3;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipeReq = 1'b0, pipeWrite = 1'b0;
    logic [AW-1:0] pipeAddr = '0;
    logic [DW-1:0] pipeWdata = '0;
    logic          pipeDone, pipeStall;
    logic          dbgReq = 1'b0, dbgWrite = 1'b0;
    logic [AW-1:0] dbgAddr = '0;
    logic [DW-1:0] dbgWdata = '0;
    logic          dbgDone;
    logic [DW-1:0] rdata;
    logic          memWrite;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;

    data_memory_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (L),
        .STARVE_LIMIT(SL)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .pipeReq  (pipeReq),
        .pipeWrite(pipeWrite),
        .pipeAddr (pipeAddr),
        .pipeWdata(pipeWdata),
        .pipeDone (pipeDone),
        .pipeStall(pipeStall),
        .dbgReq   (dbgReq),
        .dbgWrite (dbgWrite),
        .dbgAddr  (dbgAddr),
        .dbgWdata (dbgWdata),
        .dbgDone  (dbgDone),
        .rdata    (rdata),
        .memWrite (memWrite),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memRdata (memRdata)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural data memory (word indexed) ----------------
    function automatic logic [31:0] init_val(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'h0100_0000 + 32'(i) * 32'h11);
    endfunction

    logic        preload = 1'b1;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (memWrite) begin
            mem[memAddr[9:2]] <= memWdata;
        end
    end
    assign memRdata = mem[memAddr[9:2]];

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- cycle counter and activity monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt = 0, wr_cyc = -1, stall_cnt = 0, pdone_cnt = 0, ddone_cnt = 0;
    always @(negedge clk) begin
        if (memWrite) begin
            wr_cnt++;
            wr_cyc = cyc;
        end
        if (pipeStall) stall_cnt++;
        if (pipeDone)  pdone_cnt++;
        if (dbgDone)   ddone_cnt++;
    end

    task automatic clr_counts();
        wr_cnt = 0; wr_cyc = -1; stall_cnt = 0; pdone_cnt = 0; ddone_cnt = 0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;

    exp_t pipe_sb[$];
    exp_t dbg_sb[$];
    bit   free_run = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!free_run) begin
            if (pipeDone) begin
                chk("pipe_sb_nonempty", 32'(pipe_sb.size() != 0), 32'd1);
                if (pipe_sb.size() != 0) begin
                    e = pipe_sb.pop_front();
                    chk("pipe_done_cycle", 32'(cyc), 32'(e.exp_cyc));
                    if (e.is_read) chk("pipe_rdata", rdata, e.data);
                end
            end
            if (dbgDone) begin
                chk("dbg_sb_nonempty", 32'(dbg_sb.size() != 0), 32'd1);
                if (dbg_sb.size() != 0) begin
                    e = dbg_sb.pop_front();
                    chk("dbg_done_cycle", 32'(cyc), 32'(e.exp_cyc));
                    if (e.is_read) chk("dbg_rdata", rdata, e.data);
                end
            end
        end
    end

    // Drives one access from posedge+1 of the sample cycle, pushes its
    // expected completion, waits (bounded) for done and drops the request
    // in the cycle after done.
    task automatic do_op(input bit own, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int lat, output int start);
        exp_t        e;
        bit          seen;
        logic [31:0] aa;
        aa        = a;
        start     = cyc;
        e.is_read = ~wr;
        e.data    = wr ? 32'h0 : ref_mem[aa[9:2]];
        e.exp_cyc = cyc + lat;
        if (wr) ref_mem[aa[9:2]] = d;
        if (own) begin
            dbgReq = 1'b1; dbgWrite = wr; dbgAddr = a; dbgWdata = d;
            dbg_sb.push_back(e);
        end else begin
            pipeReq = 1'b1; pipeWrite = wr; pipeAddr = a; pipeWdata = d;
            pipe_sb.push_back(e);
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = own ? dbgDone : pipeDone;
        end
        chk(own ? "dbg_done_seen" : "pipe_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (own) dbgReq = 1'b0; else pipeReq = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  s0, s1;
        int  n_pipe, pipes_before_dbg;
        bit  got_dbg, stop;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {28'd0, pipeDone, dbgDone, memWrite, pipeStall}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWdata", memWdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        preload = 1'b0;

        // Idle: nothing happens for 10 cycles
        clr_counts();
        repeat (10) @(posedge clk);
        #1;
        chk("idle_memWrite", 32'(wr_cnt), 32'd0);
        chk("idle_stall", 32'(stall_cnt), 32'd0);
        chk("idle_done", 32'(pdone_cnt + ddone_cnt), 32'd0);

        // Pipe read of the preloaded word; done L+2 cycles counting the sample
        clr_counts();
        do_op(1'b0, 1'b0, 32'h100, 32'h0, L + 1, s0);
        chk("rd_stall_cycles", 32'(stall_cnt), 32'(L + 1));
        chk("rd_no_memWrite", 32'(wr_cnt), 32'd0);

        // Pipe write then read back
        clr_counts();
        do_op(1'b0, 1'b1, 32'h40, 32'h55AA55AA, L + 1, s0);
        chk("wr_strobe_count", 32'(wr_cnt), 32'd1);
        chk("wr_strobe_cycle", 32'(wr_cyc), 32'(s0 + L));
        chk("wr_mem_0x40", mem[16], 32'h55AA55AA);
        do_op(1'b0, 1'b0, 32'h40, 32'h0, L + 1, s0);

        // Simultaneous requests: pipe first, dbg granted in the next IDLE
        clr_counts();
        fork
            do_op(1'b0, 1'b0, 32'h8, 32'h0, L + 1, s0);
            do_op(1'b1, 1'b1, 32'hC, 32'h12345678, 2 * (L + 2) - 1, s1);
        join
        chk("sim_mem_0xC", mem[3], 32'h12345678);
        chk("sim_stall_cycles", 32'(stall_cnt), 32'(L + 1));

        // Reset in the 2nd BUSY cycle of a write aborts it
        clr_counts();
        pipeReq = 1'b1; pipeWrite = 1'b1; pipeAddr = 32'h80; pipeWdata = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #1;
        reset   = 1'b1;
        pipeReq = 1'b0;
        @(negedge clk);
        chk("abort_flags", {28'd0, pipeDone, dbgDone, memWrite, pipeStall}, 32'd0);
        chk("abort_memAddr", memAddr, 32'd0);
        chk("abort_memWdata", memWdata, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_memWrite", 32'(wr_cnt), 32'd0);
        chk("abort_no_done", 32'(pdone_cnt + ddone_cnt), 32'd0);
        chk("abort_mem_0x80", mem[32], init_val(32));
        do_op(1'b0, 1'b0, 32'h80, 32'h0, L + 1, s0);

        // Continuous pipe traffic with a waiting debug write
        free_run  = 1'b1;
        pipeWrite = 1'b0; pipeAddr = 32'h100; pipeReq = 1'b1;
        dbgWrite  = 1'b1; dbgAddr  = 32'h200; dbgWdata = 32'hA5A50001; dbgReq = 1'b1;
        n_pipe = 0; got_dbg = 1'b0; pipes_before_dbg = -1; stop = 1'b0;
        for (int k = 0; k < 400 && !stop; k++) begin
            @(negedge clk);
            if (pipeDone) n_pipe++;
            if (dbgDone && !got_dbg) begin
                got_dbg = 1'b1;
                pipes_before_dbg = n_pipe;
            end
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
            stop = got_dbg;
`else
            stop = got_dbg || (n_pipe >= 20);
`endif
        end
        @(posedge clk); #1;
        pipeReq = 1'b0;
        dbgReq  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        free_run = 1'b0;
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
        chk("starve_dbg_granted", 32'(got_dbg), 32'd1);
        chk("starve_pipes_first", 32'(pipes_before_dbg), 32'(SL));
        chk("starve_mem_0x200", mem[128], 32'hA5A50001);
`else
        chk("nostarve_dbg_done", 32'(got_dbg), 32'd0);
        chk("nostarve_pipe_count", 32'(n_pipe), 32'd20);
        chk("nostarve_mem_0x200", mem[128], init_val(128));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
